life_count_pipe: RTL and testbench
==================================

// Module: life_count_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 3-way parallel neighbour adder in the Life datapath.
//  Sums NUM_IN partial neighbour counts per beat through a 2-stage valid/ready pipeline and
//  tracks completed generations. Sits between the row-partial counters and the cell-state RAM
//  write-back. Optionally applies the B3/S23 rule to produce the cell's next state.
// PARAMETERS
//  NUM_IN  3  number of partial-count inputs per beat (>=2)
//  IN_W    2  width of each partial count
//  GEN_W   8  width of generation counter
//  SUM_W   (localparam) $clog2(NUM_IN*(2**IN_W-1)+1); 4 for defaults
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  in_valid   in   1             input beat valid
//  in_ready   out  1             block accepts beat this cycle
//  in_cnt     in   NUM_IN*IN_W   packed partial counts, count i at [i*IN_W +: IN_W]
//  in_center  in   1             current state of the centre cell (excluded from counts)
//  in_last    in   1             last cell of the generation
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts result
//  out_sum    out  SUM_W         neighbour count
//  out_alive  out  1             next cell state (see CONFIGURATION)
//  out_last   out  1             in_last carried with the beat
//  gen_count  out  GEN_W         completed generations
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valids 0, out_valid=0, out_sum=0, out_alive=0,
//    out_last=0, gen_count=0; in_ready=1 from the first cycle after release.
//  - Transfer = valid&ready same cycle. No combinational path from in_* to out_*.
//  - Stage 1: on transfer, registers lo = sum of counts [0..NUM_IN/2-1] and hi = sum of the
//    rest (each zero-extended to SUM_W), plus center/last.
//  - Stage 2 (output reg): out_sum = lo+hi; center/last forwarded; out_alive computed here.
//  - Latency 2 cycles, throughput 1 beat/cycle when out_ready=1.
//  - Stage advances when its successor is empty or draining same cycle:
//    s2_load = s1_valid & (~out_valid | out_ready); in_ready = ~s1_valid | s2_load.
//    in_ready depends on out_ready combinationally (no skid buffer).
//  - out_* hold stable while out_valid & ~out_ready (AXI-style; no dropping, no duplication).
//  - Arithmetic: SUM_W sized for maximum, never overflows; no saturation needed.
//  - gen_count increments by 1 on each output transfer with out_last=1; wraps 2**GEN_W-1 -> 0.
//  - Simultaneous input and output transfer on a full pipe: both occur, no bubble.
//  - Reset mid-operation: in-flight beats discarded, gen_count cleared.
// CONFIGURATION
//  LIFE_RULE_EN defined: out_alive = (out_sum==3) | (center & out_sum==2), registered in stage 2.
//  LIFE_RULE_EN undefined: out_alive constant 0; center pipeline bit may be optimised away;
//    out_sum and all timing unchanged.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 beats in flight -> out_valid=0, gen_count=0 immediately.
//  2 Single beat cnt={2,3,3} (=8) center=0, out_ready=1 -> out_valid 2 cycles later, out_sum=8.
//  3 Rule (LIFE_RULE_EN): sums 3/c0->1, 2/c1->1, 2/c0->0, 4/c1->0, 9/c1->0; undefined -> all 0.
//  4 Backpressure: 5 back-to-back beats, out_ready=0 for 4 cycles -> in_ready=0 after 2 beats
//    held; outputs stable; all 5 results delivered in order, none lost/duplicated.
//  5 Wrap: GEN_W=2, 5 beats each in_last=1 -> gen_count 1,2,3,0,1.
//  6 Random valid/ready toggling, NUM_IN=5, IN_W=3 -> scoreboard sum match, SUM_W=6, max 35.

Source files
------------

// File: rtl/life_count_pipe_if.sv
// Stream bundle for life_count_pipe: partial-count beats in, neighbour count / next state out.
// slave is the pipeline's view, master is the producer/consumer view.
interface life_count_pipe_if #(
    parameter int NUM_IN = 3,
    parameter int IN_W   = 2
) ();
    localparam int SUM_W = $clog2(NUM_IN * (2**IN_W - 1) + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_IN*IN_W-1:0] in_cnt;
    logic                   in_center;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [SUM_W-1:0]       out_sum;
    logic                   out_alive;
    logic                   out_last;

    modport master (
        output in_valid, in_cnt, in_center, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_alive, out_last
    );

    modport slave (
        input  in_valid, in_cnt, in_center, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_alive, out_last
    );
endinterface

// File: rtl/life_count_pipe.sv
// Sums NUM_IN partial neighbour counts per beat and counts generations; LIFE_RULE_EN adds the B3/S23 next state.
// Latency: 2 cycles from input transfer to out_valid, 1 beat/cycle sustained.
// Backpressure: out_ready feeds in_ready combinationally (no skid); outputs hold while stalled.
module life_count_pipe #(
    parameter int NUM_IN = 3,
    parameter int IN_W   = 2,
    parameter int GEN_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    life_count_pipe_if.slave bus,
    output logic [GEN_W-1:0] gen_count
);
    localparam int SUM_W = $clog2(NUM_IN * (2**IN_W - 1) + 1);
    localparam int N_LO  = NUM_IN / 2;

    logic             s1_valid;
    logic             s1_center;
    logic             s1_last;
    logic [SUM_W-1:0] s1_lo;
    logic [SUM_W-1:0] s1_hi;
    logic [SUM_W-1:0] lo_sum;
    logic [SUM_W-1:0] hi_sum;
    logic [SUM_W-1:0] s2_sum;
    logic             s2_alive;
    logic             s2_load;
    logic             in_xfer;
    logic             out_xfer;

    // Split the adder tree so each stage carries roughly half the additions.
    always_comb begin
        lo_sum = '0;
        hi_sum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i < N_LO) lo_sum = lo_sum + SUM_W'(bus.in_cnt[i*IN_W +: IN_W]);
            else          hi_sum = hi_sum + SUM_W'(bus.in_cnt[i*IN_W +: IN_W]);
        end
    end

    assign s2_load      = s1_valid & (~bus.out_valid | bus.out_ready);
    assign bus.in_ready = ~s1_valid | s2_load;
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign out_xfer     = bus.out_valid & bus.out_ready;
    assign s2_sum       = s1_lo + s1_hi;

`ifdef LIFE_RULE_EN
    assign s2_alive = (s2_sum == SUM_W'(3)) | (s1_center & (s2_sum == SUM_W'(2)));
`else
    // Centre bit still travels so the rule can be re-enabled without retiming; it folds away here.
    assign s2_alive = s1_center & 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_hi     <= '0;
            s1_center <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (in_xfer) begin
                s1_lo     <= lo_sum;
                s1_hi     <= hi_sum;
                s1_center <= bus.in_center;
                s1_last   <= bus.in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_alive <= 1'b0;
            bus.out_last  <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= s2_sum;
            bus.out_alive <= s2_alive;
            bus.out_last  <= s1_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        gen_count <= '0;
        else if (out_xfer && bus.out_last) gen_count <= gen_count + 1'b1;
    end
endmodule

// File: tb/tb_life_count_pipe.sv
// Directed bench for life_count_pipe: default build, a 2-bit generation counter and a 5x3-bit wide variant.
module tb_life_count_pipe;
`ifdef LIFE_RULE_EN
    localparam bit RULE_ON = 1'b1;
`else
    localparam bit RULE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] gen_a;
    logic [1:0] gen_w;
    logic [7:0] gen_x;

    int n_checks = 0;
    int n_fail   = 0;
    int qa[$];
    int qx[$];
    int exp_gen_a = 0;
    int nrecv_a   = 0;
    int nrecv_x   = 0;
    bit hold_a    = 1'b0;
    logic [3:0] prev_sum;
    logic       prev_alive;
    logic       prev_last;

    always #5 clk = ~clk;

    life_count_pipe_if                          bus_a ();
    life_count_pipe_if                          bus_w ();
    life_count_pipe_if #(.NUM_IN(5), .IN_W(3))  bus_x ();

    life_count_pipe                            u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .gen_count(gen_a));
    life_count_pipe #(.GEN_W(2))               u_w (.clk(clk), .rst_n(rst_n), .bus(bus_w), .gen_count(gen_w));
    life_count_pipe #(.NUM_IN(5), .IN_W(3))    u_x (.clk(clk), .rst_n(rst_n), .bus(bus_x), .gen_count(gen_x));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sum3(input logic [5:0] c);
        return int'(c[1:0]) + int'(c[3:2]) + int'(c[5:4]);
    endfunction

    function automatic int sum5(input logic [14:0] c);
        int s = 0;
        for (int i = 0; i < 5; i++) s += int'(c[i*3 +: 3]);
        return s;
    endfunction

    function automatic logic rule_alive(input int s, input logic c);
        return RULE_ON && ((s == 3) || (c && s == 2));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [5:0] cnt, input logic c, input logic l);
        logic acc;
        bus_a.in_valid  = 1'b1;
        bus_a.in_cnt    = cnt;
        bus_a.in_center = c;
        bus_a.in_last   = l;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = bus_a.in_valid & bus_a.in_ready;
            tick();
            if (acc) return;
        end
        check_eq("a_accept_timeout", 32'(0), 32'(1));
    endtask

    // Scoreboard + stall-stability monitor for the default instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            exp_gen_a = 0;
            hold_a    = 1'b0;
        end else begin
            if (hold_a) begin
                check_eq("a_hold_valid", 32'(bus_a.out_valid), 32'(1));
                check_eq("a_hold_sum",   32'(bus_a.out_sum),   32'(prev_sum));
                check_eq("a_hold_alive", 32'(bus_a.out_alive), 32'(prev_alive));
                check_eq("a_hold_last",  32'(bus_a.out_last),  32'(prev_last));
            end
            if (bus_a.out_valid && bus_a.out_ready) begin
                if (qa.size() == 0) check_eq("a_extra_out", 32'(1), 32'(0));
                else begin
                    int e;
                    e = qa.pop_front();
                    check_eq("a_sum",   32'(bus_a.out_sum),   32'(e / 4));
                    check_eq("a_alive", 32'(bus_a.out_alive), 32'((e / 2) % 2));
                    check_eq("a_last",  32'(bus_a.out_last),  32'(e % 2));
                    check_eq("a_gen",   32'(gen_a),           32'(exp_gen_a % 256));
                    if (bus_a.out_last) exp_gen_a++;
                end
                nrecv_a++;
            end
            hold_a     = bus_a.out_valid & ~bus_a.out_ready;
            prev_sum   = bus_a.out_sum;
            prev_alive = bus_a.out_alive;
            prev_last  = bus_a.out_last;
            if (bus_a.in_valid && bus_a.in_ready) begin
                int s;
                s = sum3(bus_a.in_cnt);
                qa.push_back(s * 4 + int'(rule_alive(s, bus_a.in_center)) * 2 + int'(bus_a.in_last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) qx.delete();
        else begin
            if (bus_x.out_valid && bus_x.out_ready) begin
                if (qx.size() == 0) check_eq("x_extra_out", 32'(1), 32'(0));
                else check_eq("x_sum", 32'(bus_x.out_sum), 32'(qx.pop_front()));
                nrecv_x++;
            end
            if (bus_x.in_valid && bus_x.in_ready) qx.push_back(sum5(bus_x.in_cnt));
        end
    end

    logic [5:0] rule_cnt   [5] = '{6'b00_00_11, 6'b00_01_01, 6'b00_10_00, 6'b01_01_10, 6'b11_11_11};
    logic       rule_c     [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int         rule_sum   [5] = '{3, 2, 2, 4, 9};
    logic       rule_alive_tbl [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int         wrap_exp   [5] = '{1, 2, 3, 0, 1};

    initial begin
        int n0;
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_cnt = '0; bus_a.in_center = 1'b0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
        bus_w.in_valid = 1'b0; bus_w.in_cnt = '0; bus_w.in_center = 1'b0; bus_w.in_last = 1'b0; bus_w.out_ready = 1'b1;
        bus_x.in_valid = 1'b0; bus_x.in_cnt = '0; bus_x.in_center = 1'b0; bus_x.in_last = 1'b0; bus_x.out_ready = 1'b1;

        #2;
        check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'(0));
        check_eq("rst_out_sum",   32'(bus_a.out_sum),   32'(0));
        check_eq("rst_out_alive", 32'(bus_a.out_alive), 32'(0));
        check_eq("rst_out_last",  32'(bus_a.out_last),  32'(0));
        check_eq("rst_gen",       32'(gen_a),           32'(0));
        check_eq("rst_gen_w",     32'(gen_w),           32'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(bus_a.in_ready), 32'(1));

        // Single beat {2,3,3} = 8, visible two cycles after the accepting edge.
        drive_a({2'd2, 2'd3, 2'd3}, 1'b0, 1'b1);
        bus_a.in_valid = 1'b0;
        check_eq("single_not_yet", 32'(bus_a.out_valid), 32'(0));
        tick();
        check_eq("single_valid", 32'(bus_a.out_valid), 32'(1));
        check_eq("single_sum",   32'(bus_a.out_sum),   32'(8));
        check_eq("single_last",  32'(bus_a.out_last),  32'(1));
        tick();
        check_eq("single_gen", 32'(gen_a), 32'(1));

        for (int i = 0; i < 5; i++) begin
            drive_a(rule_cnt[i], rule_c[i], 1'b0);
            bus_a.in_valid = 1'b0;
            tick();
            check_eq("rule_valid", 32'(bus_a.out_valid), 32'(1));
            check_eq("rule_sum",   32'(bus_a.out_sum),   32'(rule_sum[i]));
            check_eq("rule_alive", 32'(bus_a.out_alive), 32'(RULE_ON & rule_alive_tbl[i]));
        end
        tick();

        // Five back-to-back beats against a 4-cycle stall.
        n0 = nrecv_a;
        bus_a.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) drive_a(6'(i * 11 + 5), i[0], i == 4);
                bus_a.in_valid = 1'b0;
            end
            begin
                repeat (3) tick();
                check_eq("bp_in_ready", 32'(bus_a.in_ready), 32'(0));
                check_eq("bp_accepted", 32'(qa.size()),      32'(2));
                tick();
                bus_a.out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 30 && qa.size() != 0; k++) tick();
        repeat (2) tick();
        check_eq("bp_drained",   32'(qa.size()),      32'(0));
        check_eq("bp_delivered", 32'(nrecv_a - n0),   32'(5));
        check_eq("bp_gen",       32'(gen_a),          32'(2));

        // Generation counter wrap on a 2-bit instance.
        for (int k = 0; k < 5; k++) begin
            bus_w.in_valid = 1'b1;
            bus_w.in_last  = 1'b1;
            bus_w.in_cnt   = 6'd1;
            tick();
            bus_w.in_valid = 1'b0;
            repeat (2) tick();
            check_eq("wrap_gen", 32'(gen_w), 32'(wrap_exp[k]));
        end

        // Wide instance: maximum count first, then random valid/ready traffic.
        bus_x.in_valid = 1'b1;
        bus_x.in_cnt   = '1;
        tick();
        bus_x.in_valid = 1'b0;
        tick();
        check_eq("x_max_valid", 32'(bus_x.out_valid), 32'(1));
        check_eq("x_max_sum",   32'(bus_x.out_sum),   32'(35));
        tick();
        for (int c = 0; c < 400; c++) begin
            logic acc;
            @(negedge clk);
            acc = bus_x.in_valid & bus_x.in_ready;
            tick();
            bus_x.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus_x.in_valid || acc) begin
                bus_x.in_valid = ($urandom_range(0, 2) != 0);
                bus_x.in_cnt   = 15'($urandom);
            end
        end
        bus_x.in_valid  = 1'b0;
        bus_x.out_ready = 1'b1;
        for (int k = 0; k < 20 && qx.size() != 0; k++) tick();
        tick();
        check_eq("x_drained",   32'(qx.size()),         32'(0));
        check_eq("x_traffic",   32'(nrecv_x > 100),     32'(1));

        // Reset with two beats in flight.
        bus_a.out_ready = 1'b0;
        drive_a(6'b01_10_11, 1'b0, 1'b1);
        drive_a(6'b11_00_01, 1'b1, 1'b1);
        bus_a.in_valid = 1'b0;
        check_eq("mid_full", 32'(bus_a.out_valid), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid",    32'(bus_a.out_valid), 32'(0));
        check_eq("mid_rst_gen",      32'(gen_a),           32'(0));
        check_eq("mid_rst_in_ready", 32'(bus_a.in_ready),  32'(1));
        repeat (2) tick();
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        repeat (3) tick();
        check_eq("post_rst_flushed", 32'(bus_a.out_valid), 32'(0));
        check_eq("post_rst_gen",     32'(gen_a),           32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
